// File: rtl/mem_access_stage.sv
// mem_access_stage: LEGv8 MEM stage with a req/ready data-memory handshake, branch resolve and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT cycles and raise the sticky timeout_err flag.
module mem_access_stage #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] read2,
  input  logic [4:0]        write_reg,
  input  logic              branch,
  input  logic              uncBranch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regWrite,
  input  logic              memtoReg,
  input  logic [31:0]       instruction,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] Read_data,
  output logic [DATA_W-1:0] Alu_result_wb,
  output logic [4:0]        Write_reg_wb,
  output logic              RegWrite_wb,
  output logic              MemtoReg_wb,
  output logic [31:0]       Instruction_mem_wb,
  output logic              timeout_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q, rw_q, mtr_q;
  logic [4:0]        wr_q;
  logic [31:0]       ins_q;
  logic              waiting, access, abort, done, latch;
  assign waiting       = state_q == WAIT;
  assign access        = memread | memwrite;
  assign dmem_req      = ~reset & ~abort & (waiting | access);
  assign dmem_we       = waiting ? we_q : memwrite;
  assign dmem_addr     = waiting ? addr_q : alu_result;
  assign dmem_wdata    = waiting ? wdata_q : read2;
  assign done          = dmem_req & dmem_ready;
  assign stall         = dmem_req & ~dmem_ready;
  assign latch         = stall & ~waiting;
  assign state_d       = stall ? WAIT : IDLE;
  assign pc_src        = ~reset & ~stall & ((branch & zero) | uncBranch);
  assign branch_target = add_result;
`ifdef MEM_TIMEOUT_EN
  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q;
  logic          terr_q;
  // cnt_q holds the index of the current WAIT cycle, starting at 1
  assign abort       = waiting & (cnt_q == TMAX) & ~dmem_ready;
  assign timeout_err = terr_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= latch ? CW'(1) : (waiting ? cnt_q + CW'(1) : cnt_q);
      terr_q <= terr_q | abort;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      wdata_q            <= '0;
      we_q               <= 1'b0;
      rw_q               <= 1'b0;
      mtr_q              <= 1'b0;
      wr_q               <= '0;
      ins_q              <= '0;
      Read_data          <= '0;
      Alu_result_wb      <= '0;
      Write_reg_wb       <= '0;
      RegWrite_wb        <= 1'b0;
      MemtoReg_wb        <= 1'b0;
      Instruction_mem_wb <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= alu_result;
        wdata_q <= read2;
        we_q    <= memwrite;
        rw_q    <= regWrite;
        mtr_q   <= memtoReg;
        wr_q    <= write_reg;
        ins_q   <= instruction;
      end
      // Bubble on stall or abort; data fields keep their previous value
      if (stall | abort) begin
        Write_reg_wb       <= '0;
        RegWrite_wb        <= 1'b0;
        MemtoReg_wb        <= 1'b0;
        Instruction_mem_wb <= '0;
      end else begin
        Read_data          <= (done & ~dmem_we) ? dmem_rdata : '0;
        Alu_result_wb      <= dmem_addr;
        Write_reg_wb       <= waiting ? wr_q : write_reg;
        RegWrite_wb        <= waiting ? rw_q : regWrite;
        MemtoReg_wb        <= waiting ? mtr_q : memtoReg;
        Instruction_mem_wb <= waiting ? ins_q : instruction;
      end
    end
  end
endmodule
